// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: queues pixel writes, turns packed x/y into linear framebuffer addresses and runs full-screen clears.
// Build option: define PIXEL_SINK_TRANSPARENT_EN to discard incoming writes whose colour equals TRANSPARENT_KEY.
module vga_pixel_sink #(
    parameter int         FIFO_DEPTH      = 8,
    parameter int         H_RES           = 160,
    parameter int         V_RES           = 120,
    parameter logic [8:0] TRANSPARENT_KEY = 9'h1C7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  colours,
    input  logic [14:0] coordinates,
    input  logic        VGA_write_enable,
    output logic        pixel_ready,
    input  logic        clear_req,
    input  logic [8:0]  clear_colour,
    output logic        clear_done,
    output logic        busy,
    output logic [14:0] fb_addr,
    output logic [8:0]  fb_data,
    output logic        fb_wren,
    output logic [7:0]  dropped_count
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] H_LIM      = 16'(H_RES);
    localparam logic [15:0] V_LIM      = 16'(V_RES);
    localparam logic [14:0] CLEAR_LAST = 15'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t        state, next_state;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [14:0]   clear_cnt;
    logic [8:0]    fill_colour;
    logic          full, empty, in_range, is_key, wr_attempt;
    logic          push, pop, drop, start_clear, clear_wr;
    logic [23:0]   head;

    // Row offset: y*160 as two shifts; other widths fall back to a constant multiply.
    function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
        logic [14:0] row;
        if (H_RES == 160) row = ({8'd0, py} << 7) + ({8'd0, py} << 5);
        else              row = 15'({8'd0, py} * 15'(H_RES));
        return row + {7'd0, px};
    endfunction

`ifdef PIXEL_SINK_TRANSPARENT_EN
    assign is_key = (colours == TRANSPARENT_KEY);
`else
    logic unused_key;
    assign is_key     = 1'b0;
    assign unused_key = ^TRANSPARENT_KEY;
`endif

    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign pixel_ready = !full;
    assign in_range    = ({8'd0, coordinates[14:7]} < H_LIM) && ({9'd0, coordinates[6:0]} < V_LIM);
    assign wr_attempt  = VGA_write_enable && in_range && !is_key;
    // A same-cycle pop frees a slot, so a full FIFO being drained still accepts.
    assign push        = wr_attempt && (!full || pop);
    assign drop        = wr_attempt && full && !pop;
    assign head        = mem[rd_ptr];
    assign busy        = (state != S_IDLE) || !empty || fb_wren;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (clear_req) next_state = S_CLEAR;
            S_CLEAR: if (clear_cnt == CLEAR_LAST) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        start_clear = 1'b0;
        pop         = 1'b0;
        clear_wr    = 1'b0;
        clear_done  = 1'b0;
        case (state)
            S_IDLE: begin
                start_clear = clear_req;
                pop         = !clear_req && !empty;
            end
            S_CLEAR: clear_wr   = 1'b1;
            S_DONE:  clear_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {coordinates, colours};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dropped_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
            if (drop && dropped_count != 8'hFF) dropped_count <= dropped_count + 8'd1;
        end
    end

    // Framebuffer port is registered: a pop or clear step shows up one cycle later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fb_wren     <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            clear_cnt   <= '0;
            fill_colour <= '0;
        end else begin
            fb_wren <= pop || clear_wr;
            if (start_clear) begin
                fill_colour <= clear_colour;
                clear_cnt   <= '0;
            end else if (clear_wr) begin
                clear_cnt <= clear_cnt + 15'd1;
            end
            if (clear_wr) begin
                fb_addr <= clear_cnt;
                fb_data <= fill_colour;
            end else if (pop) begin
                fb_addr <= pix_addr(head[23:16], head[15:9]);
                fb_data <= head[8:0];
            end
        end
    end
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Testbench for vga_pixel_sink: randomized pixel traffic and clears checked against a queue-based screen-write model.
module tb_vga_pixel_sink;
    localparam int         H_RES        = 160;
    localparam int         V_RES        = 120;
    localparam int         CLEAR_PIXELS = H_RES * V_RES;
    localparam logic [8:0] KEY          = 9'h1C7;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [8:0]  colours = '0;
    logic [14:0] coordinates = '0;
    logic        VGA_write_enable = 1'b0;
    logic        pixel_ready;
    logic        clear_req = 1'b0;
    logic [8:0]  clear_colour = '0;
    logic        clear_done;
    logic        busy;
    logic [14:0] fb_addr;
    logic [8:0]  fb_data;
    logic        fb_wren;
    logic [7:0]  dropped_count;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];
    int exp_dropped = 0;

    vga_pixel_sink dut (
        .clk(clk), .resetn(resetn), .colours(colours), .coordinates(coordinates),
        .VGA_write_enable(VGA_write_enable), .pixel_ready(pixel_ready),
        .clear_req(clear_req), .clear_colour(clear_colour), .clear_done(clear_done),
        .busy(busy), .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    function automatic bit model_accepts(input int x, input int y, input logic [8:0] c);
        if (x >= H_RES || y >= V_RES) return 1'b0;
`ifdef PIXEL_SINK_TRANSPARENT_EN
        if (c == KEY) return 1'b0;
`endif
        return (c === c);
    endfunction

    function automatic logic [23:0] model_word(input int x, input int y, input logic [8:0] c);
        return {15'(y * H_RES + x), c};
    endfunction

    function automatic logic [8:0] rand_colour();
        logic [8:0] c;
        do c = 9'($urandom_range(0, 511)); while (c == KEY);
        return c;
    endfunction

    task automatic model_push(input int x, input int y, input logic [8:0] c);
        if (exp_q.size() < 8) exp_q.push_back(model_word(x, y, c));
        else if (exp_dropped < 255) exp_dropped++;
    endtask

    task automatic drive_pixel(input bit we, input int x, input int y, input logic [8:0] c);
        VGA_write_enable = we;
        coordinates      = {8'(x), 7'(y)};
        colours          = c;
    endtask

    task automatic test_reset();
        logic [35:0] got;
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        got = {fb_wren, fb_addr, fb_data, clear_done, dropped_count, busy, pixel_ready};
        checks++;
        if (got !== {1'b0, 15'd0, 9'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, {1'b0, 15'd0, 9'd0, 1'b0, 8'd0, 1'b0, 1'b1});
        end
        resetn = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk); drive_pixel(1'b1, 5, 3, 9'h03F);
        @(negedge clk); drive_pixel(1'b0, 0, 0, 9'd0);
        checks++;
        if (fb_wren !== 1'b0) begin errors++; $display("FAIL single_early: fb_wren got %b expected 0", fb_wren); end
        @(negedge clk);
        checks++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 15'd485, 9'h03F}) begin
            errors++;
            $display("FAIL single_write: got wren=%b addr=%0d data=%h expected wren=1 addr=485 data=03f", fb_wren, fb_addr, fb_data);
        end
        @(negedge clk); drive_pixel(1'b1, 159, 119, 9'h155);
        checks++;
        if ({fb_wren, busy} !== 2'b00) begin errors++; $display("FAIL single_idle: wren/busy got %b expected 00", {fb_wren, busy}); end
        @(negedge clk); drive_pixel(1'b0, 0, 0, 9'd0);
        @(negedge clk);
        checks++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 15'd19199, 9'h155}) begin
            errors++;
            $display("FAIL corner_write: got wren=%b addr=%0d data=%h expected wren=1 addr=19199 data=155", fb_wren, fb_addr, fb_data);
        end
    endtask

    task automatic test_out_of_range();
        int seen = 0;
        @(negedge clk); drive_pixel(1'b1, 160, 0, rand_colour());
        @(negedge clk); if (fb_wren === 1'b1) seen++; drive_pixel(1'b1, 0, 120, rand_colour());
        @(negedge clk); if (fb_wren === 1'b1) seen++; drive_pixel(1'b0, 0, 0, 9'd0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL oor_busy: got %b expected 0", busy); end
        repeat (3) begin @(negedge clk); if (fb_wren === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL oor_writes: got %0d expected 0", seen); end
        checks++;
        if (dropped_count !== 8'(exp_dropped)) begin errors++; $display("FAIL oor_dropped: got %0d expected %0d", dropped_count, exp_dropped); end
    endtask

    task automatic test_clear_overflow();
        int clear_writes = 0, clear_bad = 0, done_pulses = 0, ready_bad = 0, pix_writes = 0;
        logic last_done = 1'b0;
        logic [23:0] w;
        int x, y;
        logic [8:0] c;
        @(negedge clk);
        clear_req = 1'b1; clear_colour = 9'h000;
        for (int k = 0; k < CLEAR_PIXELS + 200 && pix_writes < 8; k++) begin
            @(negedge clk);
            if (clear_done === 1'b1) done_pulses++;
            if (fb_wren === 1'b1) begin
                if (clear_writes < CLEAR_PIXELS) begin
                    if ({fb_addr, fb_data} !== {15'(clear_writes), 9'h000}) clear_bad++;
                    clear_writes++;
                    if (clear_writes == CLEAR_PIXELS) last_done = clear_done;
                end else begin
                    pix_writes++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL clear_drain_extra: got addr=%0d data=%h expected no write", fb_addr, fb_data);
                    end else begin
                        w = exp_q.pop_front();
                        if ({fb_addr, fb_data} !== w) begin
                            errors++; $display("FAIL clear_drain_pixel: got %h expected %h", {fb_addr, fb_data}, w);
                        end
                    end
                end
            end
            clear_req = (k == 200);
            if (k == 200) clear_colour = 9'h1FF;
            if (k < 10) begin
                if (pixel_ready !== 1'(exp_q.size() < 8)) ready_bad++;
                x = $urandom_range(0, H_RES - 1); y = $urandom_range(0, V_RES - 1); c = rand_colour();
                drive_pixel(1'b1, x, y, c);
                model_push(x, y, c);
            end else begin
                drive_pixel(1'b0, 0, 0, 9'd0);
            end
        end
        checks++;
        if (clear_writes != CLEAR_PIXELS) begin errors++; $display("FAIL clear_count: got %0d expected %0d", clear_writes, CLEAR_PIXELS); end
        checks++;
        if (clear_bad != 0) begin errors++; $display("FAIL clear_sequence: got %0d bad writes expected 0", clear_bad); end
        checks++;
        if (last_done !== 1'b1) begin errors++; $display("FAIL clear_done_timing: got %b expected 1", last_done); end
        checks++;
        if (done_pulses != 1) begin errors++; $display("FAIL clear_done_pulses: got %0d expected 1", done_pulses); end
        checks++;
        if (ready_bad != 0) begin errors++; $display("FAIL clear_pixel_ready: got %0d wrong cycles expected 0", ready_bad); end
        checks++;
        if (pix_writes != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL clear_drain_count: got %0d writes (%0d left) expected 8 (0 left)", pix_writes, exp_q.size());
        end
        checks++;
        if (dropped_count !== 8'(exp_dropped)) begin errors++; $display("FAIL clear_dropped: got %0d expected %0d", dropped_count, exp_dropped); end
        @(negedge clk);
        checks++;
        if ({fb_wren, busy, clear_done} !== 3'b000) begin errors++; $display("FAIL clear_settle: got %b expected 000", {fb_wren, busy, clear_done}); end
    endtask

    task automatic test_random_stream(input int n, input bit dense);
        int writes = 0, first = -1, last = -1, pushed = 0;
        int x, y;
        logic [8:0] c;
        logic [23:0] w;
        for (int k = 0; k < n + 10; k++) begin
            @(negedge clk);
            if (fb_wren === 1'b1) begin
                writes++;
                if (first < 0) first = k;
                last = k;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got addr=%0d data=%h expected no write", fb_addr, fb_data);
                end else begin
                    w = exp_q.pop_front();
                    if ({fb_addr, fb_data} !== w) begin errors++; $display("FAIL stream_pixel: got %h expected %h", {fb_addr, fb_data}, w); end
                end
            end
            if (k < n && (dense || $urandom_range(0, 3) != 0)) begin
                x = $urandom_range(0, H_RES - 1); y = $urandom_range(0, V_RES - 1); c = rand_colour();
                if (!dense) begin
                    case ($urandom_range(0, 9))
                        0: x = $urandom_range(H_RES, 255);
                        1: y = $urandom_range(V_RES, 127);
                        2: c = KEY;
                        default: ;
                    endcase
                end
                drive_pixel(1'b1, x, y, c);
                if (model_accepts(x, y, c)) begin exp_q.push_back(model_word(x, y, c)); pushed++; end
            end else begin
                drive_pixel(1'b0, 0, 0, 9'd0);
            end
        end
        checks++;
        if (writes != pushed || exp_q.size() != 0) begin
            errors++; $display("FAIL stream_count: got %0d writes (%0d left) expected %0d", writes, exp_q.size(), pushed);
        end
        if (dense) begin
            checks++;
            if (last - first + 1 != writes) begin errors++; $display("FAIL stream_gaps: got span %0d expected %0d", last - first + 1, writes); end
        end
        checks++;
        if (dropped_count !== 8'(exp_dropped)) begin errors++; $display("FAIL stream_dropped: got %0d expected %0d", dropped_count, exp_dropped); end
    endtask

    task automatic test_transparent();
        int seen = 0;
        logic [23:0] got = '0;
        @(negedge clk); drive_pixel(1'b1, 10, 10, KEY);
        @(negedge clk); drive_pixel(1'b0, 0, 0, 9'd0);
        repeat (4) begin
            @(negedge clk);
            if (fb_wren === 1'b1) begin seen++; got = {fb_addr, fb_data}; end
        end
`ifdef PIXEL_SINK_TRANSPARENT_EN
        checks++;
        if (seen != 0) begin errors++; $display("FAIL transparent_filtered: got %0d writes expected 0", seen); end
`else
        checks++;
        if (seen != 1 || got !== {15'd1610, KEY}) begin
            errors++; $display("FAIL transparent_written: got %0d writes last %h expected 1 write %h", seen, got, {15'd1610, KEY});
        end
`endif
    endtask

    task automatic test_reset_mid_clear();
        int found = 0, stray = 0;
        int x, y;
        logic [8:0] c;
        logic [35:0] got;
        @(negedge clk);
        clear_req = 1'b1; clear_colour = rand_colour();
        for (int k = 0; k < 6000 && found == 0; k++) begin
            @(negedge clk);
            clear_req = 1'b0;
            if (fb_wren === 1'b1 && fb_addr === 15'd5000) begin
                found = 1;
            end else if (k < 9) begin
                x = $urandom_range(0, H_RES - 1); y = $urandom_range(0, V_RES - 1); c = rand_colour();
                drive_pixel(1'b1, x, y, c);
                model_push(x, y, c);
            end else begin
                drive_pixel(1'b0, 0, 0, 9'd0);
            end
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL mid_clear_reach: got no write at 5000 expected one within 6000 cycles"); end
        checks++;
        if (dropped_count !== 8'(exp_dropped)) begin errors++; $display("FAIL mid_clear_dropped: got %0d expected %0d", dropped_count, exp_dropped); end
        #2 resetn = 1'b0;
        #1 got = {fb_wren, fb_addr, fb_data, clear_done, dropped_count, busy, pixel_ready};
        checks++;
        if (got !== {1'b1 ^ 1'b1, 15'd0, 9'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL mid_clear_reset: got %h expected %h", got, {1'b0, 15'd0, 9'd0, 1'b0, 8'd0, 1'b0, 1'b1});
        end
        exp_q.delete();
        exp_dropped = 0;
        @(negedge clk); resetn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (fb_wren === 1'b1 || clear_done === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL mid_clear_stray: got %0d active cycles expected 0", stray); end
        c = rand_colour();
        @(negedge clk); drive_pixel(1'b1, 7, 2, c);
        @(negedge clk); drive_pixel(1'b0, 0, 0, 9'd0);
        @(negedge clk);
        checks++;
        if ({fb_wren, fb_addr, fb_data} !== {1'b1, 15'd327, c}) begin
            errors++; $display("FAIL post_reset_write: got wren=%b addr=%0d data=%h expected wren=1 addr=327 data=%h", fb_wren, fb_addr, fb_data, c);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_out_of_range();
        test_clear_overflow();
        test_random_stream(40, 1'b1);
        test_random_stream(80, 1'b0);
        test_transparent();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
